// File: rtl/stack_sequencer.sv
// stack_sequencer: pushes/pops a masked set of registers to/from a full-descending memory stack
// by driving register_file controls and a req/ack memory port. Define STACK_SEQ_TIMEOUT_EN for the ack watchdog.

package reg_pkg;
  typedef enum logic [3:0] {
    R0, R1, R2, R3, R4, R5, R6, R7,
    R8, R9, R10, R11, R12, SP, LR, PC
  } reg_e;
endpackage

module stack_sequencer
  import reg_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pop,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ack,
  output logic                oe_a,
  output logic                oe_b,
  output logic                ld,
  output reg_e                sel_a,
  output reg_e                sel_b,
  output reg_e                sel_in,
  output logic                pre_dec_sp,
  output logic                post_inc_sp
);

  localparam int SEL_W = $bits(reg_e);
  // A non-positive limit leaves the watchdog permanently disarmed.
  localparam bit WDOG_ON = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DEC, S_WRITE, S_READ, S_INC, S_DONE, S_ABORT
  } state_e;

  state_e              state, state_nx;
  logic                pop_q;
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] mask_start;
  logic [NUM_REGS-1:0] pick_bit;
  reg_e                cur;
  reg_e                pick;
  logic                timeout;

  function automatic reg_e highest_set(input logic [NUM_REGS-1:0] m);
    reg_e r;
    r = R0;
    for (int i = 0; i < NUM_REGS; i++)
      if (m[i]) r = reg_e'(SEL_W'(i));
    return r;
  endfunction

  function automatic reg_e lowest_set(input logic [NUM_REGS-1:0] m);
    reg_e r;
    r = R0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (m[i]) r = reg_e'(SEL_W'(i));
    return r;
  endfunction

  // SP is never transferred: its bit is dropped as the mask is captured.
  always_comb begin
    mask_start     = reg_mask;
    mask_start[SP] = 1'b0;
  end

  // Push walks high->low and pop walks low->high so a matching pop undoes a push.
  assign pick = pop_q ? lowest_set(mask_q) : highest_set(mask_q);

  always_comb begin
    pick_bit       = '0;
    pick_bit[pick] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pop_q  <= 1'b0;
      mask_q <= '0;
      cur    <= R0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            pop_q  <= pop;
            mask_q <= mask_start;
          end
        end
        S_SCAN: begin
          if (|mask_q) begin
            cur    <= pick;
            mask_q <= mask_q & ~pick_bit;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_SEQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside the access states, so it starts clean on every WRITE/READ entry.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state != S_WRITE && state != S_READ)
      wait_cnt <= '0;
    else if (!mem_ack)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err     = (state == S_ABORT);
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    oe_a        = 1'b0;
    oe_b        = 1'b0;
    ld          = 1'b0;
    sel_a       = R0;
    sel_b       = R0;
    sel_in      = R0;
    pre_dec_sp  = 1'b0;
    post_inc_sp = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (!(|mask_q))  state_nx = S_DONE;
        else if (pop_q)  state_nx = S_READ;
        else             state_nx = S_DEC;
      end
      S_DEC: begin
        busy       = 1'b1;
        pre_dec_sp = 1'b1;
        sel_in     = SP;
        state_nx   = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        oe_a    = 1'b1;
        sel_a   = SP;
        oe_b    = 1'b1;
        sel_b   = cur;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack)                   state_nx = S_SCAN;
        else if (WDOG_ON && timeout)   state_nx = S_ABORT;
      end
      S_READ: begin
        busy    = 1'b1;
        oe_a    = 1'b1;
        sel_a   = SP;
        mem_req = 1'b1;
        // Read data sits on the register_file input only during the ack cycle, so ld follows ack directly.
        if (mem_ack) begin
          ld       = 1'b1;
          sel_in   = cur;
          state_nx = S_INC;
        end else if (WDOG_ON && timeout) begin
          state_nx = S_ABORT;
        end
      end
      S_INC: begin
        busy        = 1'b1;
        post_inc_sp = 1'b1;
        sel_in      = SP;
        state_nx    = S_SCAN;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ABORT: begin
        busy     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: behavioural register file + memory around the DUT, checked against
// a register-level stack model. Build with STACK_SEQ_TIMEOUT_EN to exercise the watchdog.

module tb_stack_sequencer;
  import reg_pkg::*;

`ifdef STACK_SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 4;
`else
  localparam int TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] reg_mask = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, err, mem_req, mem_we, oe_a, oe_b, ld, pre_dec_sp, post_inc_sp;
  reg_e        sel_a, sel_b, sel_in;

  stack_sequencer #(.NUM_REGS(16), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .pop(pop), .reg_mask(reg_mask),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .oe_a(oe_a), .oe_b(oe_b), .ld(ld),
    .sel_a(sel_a), .sel_b(sel_b), .sel_in(sel_in),
    .pre_dec_sp(pre_dec_sp), .post_inc_sp(post_inc_sp)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] addr; logic [15:0] data; } wr_t;

  // Environment: register file, memory, write log and protocol counters.
  logic [15:0] rf  [16] = '{default: 16'h0};
  logic [15:0] mem [256] = '{default: 16'h0};
  logic [15:0] mem_rdata;
  wr_t         wr_log[$];
  logic        preset_en = 1'b0;
  logic [3:0]  preset_idx = '0;
  logic [15:0] preset_val = '0;
  int req_total = 0, dec_total = 0, inc_total = 0, done_total = 0, err_total = 0, proto_bad = 0;

  assign mem_rdata = mem[rf[sel_a][7:0]];

  always @(posedge clk) begin
    if (preset_en)   rf[preset_idx] <= preset_val;
    if (pre_dec_sp)  rf[SP] <= rf[SP] - 16'd1;
    if (post_inc_sp) rf[SP] <= rf[SP] + 16'd1;
    if (ld)          rf[sel_in] <= mem_rdata;
    if (mem_req && mem_we && mem_ack) begin
      mem[rf[sel_a][7:0]] <= rf[sel_b];
      wr_log.push_back({rf[sel_a][7:0], rf[sel_b]});
    end
    if (mem_req)     req_total++;
    if (pre_dec_sp)  dec_total++;
    if (post_inc_sp) inc_total++;
    if (done)        done_total++;
    if (err)         err_total++;
    if ((pre_dec_sp || post_inc_sp) && sel_in != SP) proto_bad++;
    if (mem_req && (!oe_a || sel_a != SP || (mem_we && !oe_b))) proto_bad++;
    if (ld && !(mem_req && !mem_we && mem_ack)) proto_bad++;
  end

  // Memory responder: acks in request cycle wait_cfg+1.
  int wait_cfg = 0;
  int req_cycles = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack = (req_cycles == wait_cfg);
      req_cycles++;
    end else begin
      mem_ack = 1'b0;
      req_cycles = 0;
    end
  end

  // Reference model: architectural registers and stack memory.
  logic [15:0] model_rf  [16] = '{default: 16'h0};
  logic [15:0] model_mem [256] = '{default: 16'h0};
  int n_tests = 0, n_fail = 0;
  int err_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int r, input logic [15:0] v);
    preset_idx = r[3:0];
    preset_val = v;
    preset_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preset_en  = 1'b0;
    model_rf[r] = v;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(rf[i]), 32'(model_rf[i]));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, 32'({busy, done, err, mem_req, mem_we, oe_a, oe_b, ld, pre_dec_sp, post_inc_sp}), 32'd0);
    check({tag, "_sels"}, 32'({sel_a, sel_b, sel_in}), 32'd0);
  endtask

  task automatic start_seq(input bit p, input logic [15:0] m);
    start = 1'b1;
    pop = p;
    reg_mask = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pop = 1'($urandom);
    reg_mask = 16'($urandom);
  endtask

  task automatic run_seq(input string tag, input bit p, input logic [15:0] m, input int wt);
    int n, lat, wr0, req0, dec0, inc0, done0;
    bit busy_gap;
    wr_t exp_wr[$];
    n = 0;
    busy_gap = 1'b0;
    if (!p) begin
      for (int i = 15; i >= 0; i--) begin
        if (m[i] && i != int'(SP)) begin
          model_rf[SP] = model_rf[SP] - 16'd1;
          exp_wr.push_back({model_rf[SP][7:0], model_rf[i]});
          model_mem[model_rf[SP][7:0]] = model_rf[i];
          n++;
        end
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (m[i] && i != int'(SP)) begin
          model_rf[i] = model_mem[model_rf[SP][7:0]];
          model_rf[SP] = model_rf[SP] + 16'd1;
          n++;
        end
      end
    end

    wait_cfg = wt;
    wr0 = wr_log.size(); req0 = req_total; dec0 = dec_total; inc0 = inc_total; done0 = done_total;
    start_seq(p, m);
    lat = 1;
    while (!done && lat < 300) begin
      if (!busy) busy_gap = 1'b1;
      start = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(3 * n + 2 + n * wt));
    check({tag, "_busy_held"}, 32'(busy_gap), 32'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_total - done0), 32'd1);
    check({tag, "_req_cycles"}, 32'(req_total - req0), 32'(n * (wt + 1)));
    check({tag, "_pre_dec"}, 32'(dec_total - dec0), 32'(p ? 0 : n));
    check({tag, "_post_inc"}, 32'(inc_total - inc0), 32'(p ? n : 0));
    check({tag, "_writes"}, 32'(wr_log.size() - wr0), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (wr0 + i < wr_log.size())
        check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[wr0 + i]), 32'(exp_wr[i]));
    check_regs(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] m;

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // Directed push / pop of R0,R1
    set_reg(0, 16'd123);
    set_reg(1, 16'd321);
    set_reg(int'(SP), 16'd100);
    run_seq("push2", 1'b0, 16'b11, 0);
    set_reg(0, 16'd0);
    set_reg(1, 16'd0);
    run_seq("pop2", 1'b1, 16'b11, 0);

    // Empty and SP-only masks
    run_seq("empty", 1'b0, 16'h0000, 0);
    run_seq("sp_only_push", 1'b0, 16'h0001 << int'(SP), 0);
    run_seq("sp_only_pop", 1'b1, 16'h0001 << int'(SP), 0);

    // Wait states with starts pulsed while busy
    set_reg(0, 16'd567);
    set_reg(int'(SP), 16'd21);
    run_seq("wait3", 1'b0, 16'b1, 3);

    // Reset during WRITE of a 2-register push
    set_reg(int'(SP), 16'd80);
    wait_cfg = 5;
    start_seq(1'b0, 16'b11);
    lat = 1;
    while (!mem_req && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rst_reach_write", 32'(lat), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_midop");
    rst = 1'b0;
    model_rf[SP] = model_rf[SP] - 16'd1;
    check_regs("rst_partial");
    run_seq("after_rst", 1'b0, 16'b11, 0);

    // Randomized push then pop of the same mask restores registers
    for (int k = 0; k < 6; k++) begin
      m = 16'($urandom);
      for (int i = 0; i < 16; i++)
        if (m[i] && i != int'(SP)) set_reg(i, 16'($urandom));
      set_reg(int'(SP), 16'($urandom_range(40, 200)));
      run_seq($sformatf("rnd%0d_push", k), 1'b0, m, $urandom_range(0, 3));
      for (int i = 0; i < 16; i++)
        if (m[i] && i != int'(SP)) set_reg(i, 16'($urandom));
      run_seq($sformatf("rnd%0d_pop", k), 1'b1, m, $urandom_range(0, 3));
    end

`ifdef STACK_SEQ_TIMEOUT_EN
    // Watchdog: memory never acks
    begin
      int done0;
      done0 = done_total;
      wait_cfg = 100000;
      start_seq(1'b0, 16'b1);
      lat = 1;
      while (!err && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("tmo_err_latency", 32'(lat), 32'd7);
      check("tmo_req_dropped", 32'(mem_req), 32'd0);
      @(negedge clk);
      check("tmo_idle", 32'({busy, err, done}), 32'd0);
      check("tmo_no_done", 32'(done_total - done0), 32'd0);
      model_rf[SP] = model_rf[SP] - 16'd1;
      err_exp = 1;
      check_regs("tmo");
      run_seq("tmo_recover", 1'b0, 16'b110, 1);
    end
`else
    // No watchdog: a long ack delay still completes
    run_seq("long_wait", 1'b1, 16'b110, 20);
`endif

    check("err_pulses", 32'(err_total), 32'(err_exp));
    check("bus_protocol", 32'(proto_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
